calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Sits directly downstream of the input unit and consumes its 32-bit two's-complement operand.
- Captures operand A on an operator key and operand B on the equals key, then executes add, sub, mul or div.
- Mul and div run multi-cycle on magnitudes; add and sub take one execute cycle.
- Drives the signed result, status flags and an entry-clear pulse back to the input unit's digit shift registers.

Parameters:
- MAG_W, 20, magnitude width used by the iterative mul/div datapath (999999 < 2^20).
- MAX_MAG, 999999, largest displayable result magnitude (6 BCD digits); any larger magnitude is an overflow.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; returns the block to S_A with all outputs cleared
- operand  input  32  two's-complement value of the current entry
- op_key  input  1  one-cycle pulse, operator key pressed
- op_code  input  2  operator, sampled with op_key: 0 add, 1 sub, 2 mul, 3 div
- eq_key  input  1  one-cycle pulse, equals key pressed
- clear  input  1  one-cycle pulse, calculator clear (C key)
- result  output  32  signed two's-complement result, held until next result or clear
- result_valid  output  1  level, high while result is displayable
- busy  output  1  high while executing
- ovf  output  1  sticky, set when |result| > MAX_MAG
- div0  output  1  sticky, set on divide by zero
- entry_clr  output  1  one-cycle pulse telling the input unit to clear its digit registers

Behaviour:
- Reset: state S_A; result=0; result_valid, busy, ovf, div0 and entry_clr = 0; A, B and opcode registers = 0.
- clear behaves as reset, except entry_clr pulses for one cycle.
- States: S_A, S_B, S_EXEC, S_RES, S_ERR.
- S_A:
  - op_key: A<=operand, opc<=op_code, entry_clr pulse, go to S_B.
  - eq_key is ignored.
- S_B:
  - eq_key: B<=operand, busy<=1, result_valid<=0, go to S_EXEC.
  - op_key alone: opc<=op_code (operator correction); A is unchanged and there is no entry_clr.
  - op_key and eq_key in the same cycle: eq_key wins using the old opc; op_key is dropped.
- S_EXEC:
  - Lasts N cycles: N=1 for add/sub, N=MAG_W for mul/div.
  - op_key and eq_key are ignored; clear and reset still take effect immediately.
- Timing: with eq_key sampled on edge E, result and result_valid update and busy falls on edge E+N+1. Add/sub results therefore appear at E+2, mul/div at E+MAG_W+1.
- Add/sub:
  - Computed in 33-bit signed arithmetic.
  - Magnitude of the 33-bit sum/difference compared against MAX_MAG.
- Mul:
  - Sign = sA xor sB.
  - Shift-add multiply of the |A| and |B| MAG_W-bit magnitudes into a 2*MAG_W product, one bit per cycle, LSB first.
  - Overflow if the product exceeds MAX_MAG.
- Div:
  - Restoring division of the magnitudes, one quotient bit per cycle, MSB first.
  - Quotient truncates toward zero; sign = sA xor sB; the remainder is discarded.
  - If B==0 on entry to S_EXEC: div0<=1 and go straight to S_ERR on the next edge, without iterating.
- Operand magnitudes above MAX_MAG cannot occur (the input is limited to 6 digits). The block still saturates the magnitude to MAG_W bits, so it is defined for any input.
- Zero result is always +0; a negative zero is never produced.
- Final check:
  - In range: result<=signed value, result_valid<=1, go to S_RES.
  - Out of range: ovf<=1, result<=0, result_valid<=0, go to S_ERR.
- S_RES:
  - op_key: A<=result (chaining), opc<=op_code, entry_clr pulse, result_valid<=0, go to S_B.
  - eq_key is ignored.
- S_ERR: only clear or reset exit. op_key and eq_key are ignored; ovf and div0 are held.
- Reset or clear mid-S_EXEC aborts the iteration with no partial result visible.
- entry_clr is exactly one cycle wide and registered.

Decomposition:
- Package calc_pkg holds:
  - opcode encodings OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - the state enum S_A..S_ERR;
  - the MAX_MAG and MAG_W defaults;
  - a to_mag/sign helper function.
- One sub-module, seq_muldiv:
  - inputs: start, mode, MAG_W-bit magnitudes;
  - outputs: 2*MAG_W-bit product or quotient, done after MAG_W cycles;
  - the FSM and add/sub stay in calc_sequencer.

Test Plan:
- Add: op_key(add) with operand=12, then eq_key with operand=-5 -> result=7, result_valid at eq edge+2, one entry_clr pulse after op_key.
- Mul: 1234 mul 567 -> result=699678, busy high for MAG_W+1 cycles; then -3 mul 333334 -> ovf=1, S_ERR, result=0.
- Div: -100 div 7 -> -14; 100 div 0 -> div0=1 on the cycle after eq; op_key and eq_key are ignored until clear, after which all flags read 0.
- Chaining: 999998 add 1 = 999999, then op_key(add) plus operand 1 and eq_key -> ovf=1; separately 5 sub 5 -> result=0 (positive zero).
- Simultaneous and ignored events: in S_B, op_key(mul) and eq_key in the same cycle execute the original add. op_key during S_EXEC changes nothing. eq_key in S_A leaves the state in S_A.
- Reset mid-operation: assert reset at cycle 10 of a div -> on the next edge all outputs are 0 and the state is S_A; a following 8 div 2 yields 4.

Source files
------------

// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator sequencer: operator encodings, the
// sequencer state enum, datapath sizing and a signed-to-magnitude helper.
// ---------------------------------------------------------------------------
package calc_pkg;

   // Width of the iterative mul/div magnitude datapath (999999 < 2^20).
   localparam int MAG_W   = 20;
   // Largest displayable result magnitude (6 BCD digits).
   localparam int MAX_MAG = 999999;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      S_A,
      S_B,
      S_EXEC,
      S_RES,
      S_ERR
   } state_e;

   typedef struct packed {
      logic             neg;
      logic [MAG_W-1:0] mag;
   } smag_t;

   // Splits a two's-complement value into sign and magnitude. The magnitude
   // saturates at MAG_W bits so the mul/div datapath is defined for any input.
   function automatic smag_t to_smag(input logic [31:0] v);
      smag_t       r;
      logic [31:0] abs_v;
      abs_v = v[31] ? (~v + 32'd1) : v;
      r.neg = v[31];
      if (abs_v > 32'((1 << MAG_W) - 1)) begin
         r.mag = '1;
      end else begin
         r.mag = abs_v[MAG_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_muldiv.sv
// ---------------------------------------------------------------------------
// seq_muldiv
// Iterative unsigned multiplier / restoring divider, one bit per cycle.
//   clk      : system clock
//   reset_i  : synchronous active-high reset (also used to abort a run)
//   start_i  : load operands and begin; iterations follow on the next W edges
//   mode_i   : 0 = multiply (LSB first), 1 = divide (MSB first)
//   a_mag_i  : multiplier / dividend magnitude
//   b_mag_i  : multiplicand / divisor magnitude
//   res_o    : 2*W-bit product, or zero-extended quotient
//   done_o   : one-cycle pulse once the W-th iteration has been written
// ---------------------------------------------------------------------------
module seq_muldiv
   import calc_pkg::*;
#(
   parameter int W = MAG_W
) (
   input  logic           clk,
   input  logic           reset_i,
   input  logic           start_i,
   input  logic           mode_i,
   input  logic [W-1:0]   a_mag_i,
   input  logic [W-1:0]   b_mag_i,
   output logic [2*W-1:0] res_o,
   output logic           done_o
);

   localparam int CNT_W = $clog2(W);

   // hi_q/lo_q are {partial product, multiplier} for mul and
   // {remainder, dividend/quotient} for div; op_q is multiplicand or divisor.
   logic [W-1:0]     hi_q, lo_q, op_q;
   logic             mode_q, run_q, done_q;
   logic [CNT_W-1:0] cnt_q;

   logic [W:0]       mul_sum;
   logic [W:0]       div_shift;
   logic             div_ge;
   logic [W-1:0]     div_diff;

   // NOTE: every variable gets a value on every pass through always_comb;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_q} : '0);
      div_shift = {hi_q, lo_q[W-1]};
      div_ge    = div_shift >= {1'b0, op_q};
      // When div_ge holds the difference is below the divisor, so the low
      // W bits of the subtraction are exact.
      div_diff  = div_shift[W-1:0] - op_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset_i) begin
         run_q  <= 1'b0;
         done_q <= 1'b0;
         mode_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            run_q  <= 1'b1;
            mode_q <= mode_i;
            cnt_q  <= '0;
         end else if (run_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(W - 1)) begin
               run_q  <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   // NOTE: the datapath registers carry no reset; they are fully reloaded on
   // start and are only observed through done_o, which is reset.
   always_ff @(posedge clk) begin
      if (start_i) begin
         hi_q <= '0;
         lo_q <= a_mag_i;
         op_q <= b_mag_i;
      end else if (run_q) begin
         if (!mode_q) begin
            hi_q <= mul_sum[W:1];
            lo_q <= {mul_sum[0], lo_q[W-1:1]};
         end else if (div_ge) begin
            hi_q <= div_diff;
            lo_q <= {lo_q[W-2:0], 1'b1};
         end else begin
            hi_q <= div_shift[W-1:0];
            lo_q <= {lo_q[W-2:0], 1'b0};
         end
      end
   end

   assign res_o  = mode_q ? {{W{1'b0}}, lo_q} : {hi_q, lo_q};
   assign done_o = done_q;

endmodule

// File: rtl/calc_sequencer.sv
// ---------------------------------------------------------------------------
// calc_sequencer
// Operator/equals sequencer for the calculator: captures A on an operator
// key and B on equals, executes add/sub (one cycle) or mul/div (MAG_W cycles
// via seq_muldiv) and reports a signed, range-checked result.
//   clk, reset         : clock, synchronous active-high reset
//   operand            : two's-complement value of the current entry
//   op_key, op_code    : operator key pulse and operator (add/sub/mul/div)
//   eq_key, clear      : equals key pulse, calculator clear pulse
//   result             : signed result, held until next result or clear
//   result_valid, busy : result displayable / executing
//   ovf, div0          : sticky overflow / divide-by-zero flags
//   entry_clr          : one-cycle pulse clearing the input digit registers
// ---------------------------------------------------------------------------
module calc_sequencer
   import calc_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] operand,
   input  logic        op_key,
   input  logic [1:0]  op_code,
   input  logic        eq_key,
   input  logic        clear,
   output logic [31:0] result,
   output logic        result_valid,
   output logic        busy,
   output logic        ovf,
   output logic        div0,
   output logic        entry_clr
);

   localparam int FIN_W = 2 * MAG_W;

   state_e             state_q;
   op_e                opc_q;
   logic [31:0]        a_q, b_q, result_q;
   logic               valid_q, busy_q, ovf_q, div0_q, entry_clr_q;
   logic               phase_q, res_neg_q;
   logic signed [32:0] as_q;

   smag_t              a_sm, op_sm;
   logic               is_muldiv, md_start, md_done;
   logic [FIN_W-1:0]   md_res;
   logic [32:0]        as_abs;
   logic [FIN_W-1:0]   fin_mag;
   logic               fin_neg, fin_ovf;
   logic [31:0]        fin_val;

   assign a_sm      = to_smag(a_q);
   assign op_sm     = to_smag(operand);
   assign is_muldiv = (opc_q == OP_MUL) || (opc_q == OP_DIV);
   // A divide by zero never starts the iterator; the FSM flags it instead.
   assign md_start  = (state_q == S_B) && eq_key && !reset && !clear && is_muldiv
                      && !((opc_q == OP_DIV) && (operand == 32'd0));

   seq_muldiv #(.W(MAG_W)) u_muldiv (
      .clk     (clk),
      .reset_i (reset | clear),
      .start_i (md_start),
      .mode_i  (opc_q == OP_DIV),
      .a_mag_i (a_sm.mag),
      .b_mag_i (op_sm.mag),
      .res_o   (md_res),
      .done_o  (md_done)
   );

   always_comb begin
      as_abs = as_q[32] ? (~as_q + 1'b1) : as_q;
      if (is_muldiv) begin
         fin_mag = md_res;
         fin_neg = res_neg_q;
      end else begin
         fin_mag = FIN_W'(as_abs);
         fin_neg = as_q[32];
      end
      fin_ovf = fin_mag > FIN_W'(MAX_MAG);
      // Negating a zero magnitude yields zero, so -0 cannot appear.
      fin_val = fin_neg ? (32'd0 - fin_mag[31:0]) : fin_mag[31:0];
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state_q     <= S_A;
         opc_q       <= OP_ADD;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
         div0_q      <= 1'b0;
         phase_q     <= 1'b0;
         res_neg_q   <= 1'b0;
         as_q        <= '0;
         // Only a clear (not a reset) tells the input unit to drop its digits.
         entry_clr_q <= !reset;
      end else begin
         entry_clr_q <= 1'b0;
         unique case (state_q)
            S_A: begin
               if (op_key) begin
                  a_q         <= operand;
                  opc_q       <= op_e'(op_code);
                  entry_clr_q <= 1'b1;
                  state_q     <= S_B;
               end
            end
            S_B: begin
               // Equals wins over a simultaneous operator key.
               if (eq_key) begin
                  b_q       <= operand;
                  res_neg_q <= a_sm.neg ^ op_sm.neg;
                  phase_q   <= 1'b0;
                  busy_q    <= 1'b1;
                  valid_q   <= 1'b0;
                  state_q   <= S_EXEC;
               end else if (op_key) begin
                  opc_q <= op_e'(op_code);
               end
            end
            S_EXEC: begin
               if ((opc_q == OP_DIV) && (b_q == 32'd0)) begin
                  div0_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_ERR;
               end else if (!is_muldiv && !phase_q) begin
                  as_q    <= (opc_q == OP_ADD)
                             ? $signed({a_q[31], a_q}) + $signed({b_q[31], b_q})
                             : $signed({a_q[31], a_q}) - $signed({b_q[31], b_q});
                  phase_q <= 1'b1;
               end else if (!is_muldiv || md_done) begin
                  busy_q <= 1'b0;
                  if (fin_ovf) begin
                     ovf_q    <= 1'b1;
                     result_q <= '0;
                     valid_q  <= 1'b0;
                     state_q  <= S_ERR;
                  end else begin
                     result_q <= fin_val;
                     valid_q  <= 1'b1;
                     state_q  <= S_RES;
                  end
               end
            end
            S_RES: begin
               if (op_key) begin
                  a_q         <= result_q;
                  opc_q       <= op_e'(op_code);
                  entry_clr_q <= 1'b1;
                  valid_q     <= 1'b0;
                  state_q     <= S_B;
               end
            end
            S_ERR: begin
               // Parked until clear or reset; flags hold.
            end
            default: state_q <= S_A;
         endcase
      end
   end

   assign result       = result_q;
   assign result_valid = valid_q;
   assign busy         = busy_q;
   assign ovf          = ovf_q;
   assign div0         = div0_q;
   assign entry_clr    = entry_clr_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_calc_sequencer
// Self-checking bench for calc_sequencer: a behavioural calculator model
// (integer arithmetic, countdown timing) is compared against the DUT every
// cycle, with directed scenarios pinned by hand-computed literals, followed
// by randomized key/operand traffic.
// ---------------------------------------------------------------------------
module tb_calc_sequencer;
   import calc_pkg::*;

   localparam int P_A = 0, P_B = 1, P_EXEC = 2, P_RES = 3, P_ERR = 4;

   logic        clk = 1'b0;
   logic        reset, op_key, eq_key, clear;
   logic [1:0]  op_code;
   logic [31:0] operand;
   logic [31:0] result;
   logic        result_valid, busy, ovf, div0, entry_clr;

   int n_cmp = 0;
   int n_bad = 0;
   bit armed = 1'b0;

   // Behavioural model state
   int          m_phase, m_op, m_left;
   logic [31:0] m_a, m_b, m_result;
   bit          m_valid, m_busy, m_ovf, m_div0, m_eclr;

   calc_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .operand      (operand),
      .op_key       (op_key),
      .op_code      (op_code),
      .eq_key       (eq_key),
      .clear        (clear),
      .result       (result),
      .result_valid (result_valid),
      .busy         (busy),
      .ovf          (ovf),
      .div0         (div0),
      .entry_clr    (entry_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic longint sat_mag(input logic [31:0] v);
      longint x;
      x = $signed(v);
      if (x < 0) x = -x;
      if (x > (64'sd1 << MAG_W) - 1) x = (64'sd1 << MAG_W) - 1;
      return x;
   endfunction

   task automatic model_finish();
      longint ra, rb, r;
      ra = $signed(m_a);
      rb = $signed(m_b);
      case (m_op)
         0: r = ra + rb;
         1: r = ra - rb;
         2: r = sat_mag(m_a) * sat_mag(m_b);
         default: r = sat_mag(m_a) / sat_mag(m_b);
      endcase
      if (m_op >= 2 && ((ra < 0) != (rb < 0))) r = -r;
      m_busy = 1'b0;
      if (r > MAX_MAG || r < -MAX_MAG) begin
         m_ovf    = 1'b1;
         m_result = '0;
         m_valid  = 1'b0;
         m_phase  = P_ERR;
      end else begin
         m_result = 32'(r);
         m_valid  = 1'b1;
         m_phase  = P_RES;
      end
   endtask

   task automatic model_step();
      if (reset || clear) begin
         m_phase = P_A; m_op = 0; m_a = '0; m_b = '0; m_result = '0;
         m_valid = 0; m_busy = 0; m_ovf = 0; m_div0 = 0;
         m_eclr  = !reset;
         return;
      end
      m_eclr = 1'b0;
      case (m_phase)
         P_A: if (op_key) begin
            m_a = operand; m_op = op_code; m_eclr = 1'b1; m_phase = P_B;
         end
         P_B: if (eq_key) begin
            m_b = operand; m_busy = 1'b1; m_valid = 1'b0; m_phase = P_EXEC;
            m_left = (m_op < 2) ? 1 : MAG_W;
         end else if (op_key) begin
            m_op = op_code;
         end
         P_EXEC: if (m_op == 3 && m_b == 0) begin
            m_div0 = 1'b1; m_busy = 1'b0; m_phase = P_ERR;
         end else if (m_left > 0) begin
            m_left--;
         end else begin
            model_finish();
         end
         P_RES: if (op_key) begin
            m_a = m_result; m_op = op_code; m_eclr = 1'b1; m_valid = 1'b0; m_phase = P_B;
         end
         default: ;
      endcase
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (armed) begin
         check("result", $signed(result), $signed(m_result));
         check("result_valid", result_valid, m_valid);
         check("busy", busy, m_busy);
         check("ovf", ovf, m_ovf);
         check("div0", div0, m_div0);
         check("entry_clr", entry_clr, m_eclr);
      end
   end

   task automatic keys(input bit o, input bit e, input logic [1:0] c, input int v);
      op_key = o; eq_key = e; op_code = c; operand = v;
      @(negedge clk);
      op_key = 1'b0; eq_key = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("idle_within_bound", n < 200, 1);
   endtask

   task automatic run(input logic [1:0] c, input int a, input int b);
      keys(1'b1, 1'b0, c, a);
      keys(1'b0, 1'b1, OP_ADD, b);
      wait_idle();
   endtask

   function automatic int rand_operand();
      int m;
      case ($urandom_range(0, 3))
         0: m = $urandom_range(0, 9);
         1: m = $urandom_range(0, 999);
         2: m = $urandom_range(0, 999999);
         default: m = 0;
      endcase
      return ($urandom_range(0, 1) == 1) ? -m : m;
   endfunction

   initial begin
      int n;
      reset = 1'b1; clear = 1'b0; op_key = 1'b0; eq_key = 1'b0;
      op_code = '0; operand = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      armed = 1'b1;

      // Reset state
      check("rst_result", $signed(result), 0);
      check("rst_valid", result_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_flags", {ovf, div0, entry_clr}, 0);

      // 12 + (-5) = 7, result at eq edge + 2
      keys(1'b1, 1'b0, OP_ADD, 12);
      check("add_entry_clr", entry_clr, 1);
      keys(1'b0, 1'b1, OP_ADD, -5);
      check("add_busy_e0", busy, 1);
      @(negedge clk);
      check("add_valid_e1", result_valid, 0);
      @(negedge clk);
      check("add_valid_e2", result_valid, 1);
      check("add_result", $signed(result), 7);
      check("add_busy_e2", busy, 0);

      // 1234 * 567 = 699678, busy for MAG_W+1 cycles
      do_clear();
      keys(1'b1, 1'b0, OP_MUL, 1234);
      keys(1'b0, 1'b1, OP_ADD, 567);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      check("mul_busy_cycles", n, MAG_W + 1);
      check("mul_result", $signed(result), 699678);

      // -3 * 333334 overflows
      do_clear();
      run(OP_MUL, -3, 333334);
      check("mul_ovf", ovf, 1);
      check("mul_ovf_result", $signed(result), 0);
      check("mul_ovf_valid", result_valid, 0);

      // -100 / 7 = -14
      do_clear();
      run(OP_DIV, -100, 7);
      check("div_result", $signed(result), -14);

      // 100 / 0 -> div0 on the cycle after eq, then keys ignored until clear
      do_clear();
      keys(1'b1, 1'b0, OP_DIV, 100);
      keys(1'b0, 1'b1, OP_ADD, 0);
      check("div0_e0", div0, 0);
      @(negedge clk);
      check("div0_e1", div0, 1);
      keys(1'b1, 1'b0, OP_ADD, 5);
      keys(1'b0, 1'b1, OP_ADD, 3);
      repeat (3) @(negedge clk);
      check("err_hold_div0", div0, 1);
      check("err_hold_busy", busy, 0);
      do_clear();
      check("clr_entry_clr", entry_clr, 1);
      check("clr_flags", {ovf, div0, result_valid}, 0);

      // Chaining: 999998 + 1 = 999999, then + 1 overflows
      run(OP_ADD, 999998, 1);
      check("chain_result", $signed(result), 999999);
      keys(1'b1, 1'b0, OP_ADD, 1);
      keys(1'b0, 1'b1, OP_ADD, 1);
      wait_idle();
      check("chain_ovf", ovf, 1);

      // 5 - 5 = +0
      do_clear();
      run(OP_SUB, 5, 5);
      check("zero_result", $signed(result), 0);
      check("zero_valid", result_valid, 1);

      // Simultaneous op(mul)+eq executes the original add; op in EXEC ignored
      do_clear();
      keys(1'b1, 1'b0, OP_ADD, 10);
      keys(1'b1, 1'b1, OP_MUL, 4);
      keys(1'b1, 1'b0, OP_SUB, 99);
      wait_idle();
      check("simul_result", $signed(result), 14);

      // eq in S_A is ignored
      do_clear();
      keys(1'b0, 1'b1, OP_ADD, 7);
      repeat (2) @(negedge clk);
      check("eq_in_a_busy", busy, 0);
      run(OP_ADD, 2, 3);
      check("after_eq_in_a", $signed(result), 5);

      // Reset in the middle of a divide
      do_clear();
      keys(1'b1, 1'b0, OP_DIV, 999999);
      keys(1'b0, 1'b1, OP_ADD, 3);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_result", $signed(result), 0);
      check("midrst_outs", {result_valid, busy, ovf, div0, entry_clr}, 0);
      run(OP_DIV, 8, 2);
      check("post_rst_div", $signed(result), 4);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         operand = rand_operand();
         op_code = 2'($urandom_range(0, 3));
         op_key  = ($urandom_range(0, 9) == 0);
         eq_key  = ($urandom_range(0, 7) == 0);
         clear   = ($urandom_range(0, 59) == 0);
         reset   = ($urandom_range(0, 499) == 0);
         @(negedge clk);
      end
      op_key = 1'b0; eq_key = 1'b0; clear = 1'b0; reset = 1'b0;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
